uart_tx: RTL

//   Memory-mapped UART transmitter peripheral of the Hack FPGA system, directly

---
 rtl/uart_tx.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: memory-mapped 8N1 serial transmitter with a small byte FIFO.
// LOAD/IN come from the write decoder; OUT is the status word for the read mux.
module uart_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        LOAD,
    input  logic [15:0] IN,
    output logic [15:0] OUT,
    output logic        TX
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [7:0]    shift, shift_d;
    logic          tx_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_d;
    logic          overrun, overrun_d;

    logic pop, push, fifo_empty, fifo_full, data_wr, ctrl_wr, bit_end;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);
    assign bit_end    = (timer == '0);
    assign ctrl_wr    = LOAD && IN[15];
    assign data_wr    = LOAD && !IN[15];
    // A full FIFO still accepts a byte when the head leaves at the same edge.
    assign push       = data_wr && (!fifo_full || pop);

    // Next-state logic: serialiser FSM, bit timer and the registered TX value.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        state_d   = state;
        timer_d   = timer;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    timer_d = BIT_LAST;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    timer_d   = BIT_LAST;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    timer_d = timer - TW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_d   = BIT_LAST;
                    shift_d   = {1'b0, shift[7:1]};
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    timer_d = timer - TW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        timer_d = BIT_LAST;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        count_d = count;
        if (push && !pop) begin
            count_d = count + CW'(1);
        end else if (pop && !push) begin
            count_d = count - CW'(1);
        end

        overrun_d = overrun;
        if (ctrl_wr) begin
            overrun_d = 1'b0;
        end else if (data_wr && !push) begin
            overrun_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            TX      <= 1'b1;
        end else begin
            state   <= state_d;
            timer   <= timer_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
            TX      <= tx_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            OUT     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count   <= count_d;
            overrun <= overrun_d;
            OUT     <= {13'b0, overrun_d, (count_d == CNT_FULL),
                        ((state_d != IDLE) || (count_d != '0))};
        end
    end

    // NOTE: storage array is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= IN[7:0];
        end
    end

endmodule
